// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX: stalls the pipe while
// iterating and returns {remainder, quotient} for the HI/LO write.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  typedef enum logic [1:0] {IDLE, RUN, DIVZERO, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;

  logic [WIDTH:0]     sh;
  logic               ge;
  logic [WIDTH-1:0]   diff, rem_nx, quo_nx;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // The shifted partial remainder needs WIDTH+1 bits; when it is >= divisor the
  // difference is known to fit in WIDTH bits, so a WIDTH-bit subtract suffices.
  assign sh     = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (sh >= {1'b0, dvs_q});
  assign diff   = sh[WIDTH-1:0] - dvs_q;
  assign rem_nx = ge ? diff : sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (divisor_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs_f(dividend_i, signed_i);
            dvs_d   = abs_f(divisor_i, signed_i);
            qneg_d  = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            rneg_d  = signed_i & dividend_i[WIDTH-1];
          end
        end
      end
      DIVZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          res_d   = '0;
        end
      end
      RUN: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DONE;
            res_d   = {neg_f(rem_nx, rneg_q && (rem_nx != '0)), neg_f(quo_nx, qneg_q)};
          end
        end
      end
      DONE: begin
        if (annul_i || !start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign busy_o   = ((state_q == IDLE) && start_i && !annul_i) ||
                    (state_q == RUN) || (state_q == DIVZERO);
  assign ready_o  = (state_q == DONE);
  assign result_o = res_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with an arithmetic/latency reference model checked every cycle.
module tb_div_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, sgn, annul;
  logic [W-1:0]  dvd, dvs;
  logic          busy, ready;
  logic [2*W-1:0] result;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
    .dividend_i(dvd), .divisor_i(dvs), .annul_i(annul),
    .busy_o(busy), .ready_o(ready), .result_o(result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // MIPS-style truncating divide done with wide integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference: cycles left until result, whether a result is presented, its value.
  int          m_left;
  bit          m_done;
  logic [63:0] m_res, m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = 64'd0;
    end else if (m_left > 0) begin
      if (annul) m_left = 0;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end
    end else if (m_done) begin
      if (annul || !start) m_done = 1'b0;
    end else if (start && !annul) begin
      m_pend = ref_div(dvd, dvs, sgn);
      m_left = (dvs == 32'd0) ? 1 : W;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", 64'(busy), 64'((m_left > 0) || (!m_done && start && !annul)));
      chk("cyc ready", 64'(ready), 64'(m_done));
      chk("cyc result", result, m_res);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk);
    #2;
    start = 1'b1; sgn = s; dvd = a; dvs = b;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp_res, input int exp_lat, input int hold);
    int n;
    bit seen;
    drive(a, b, s);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
      n++;
      if (n == 2) begin
        dvd = ~dvd; dvs = dvs + 32'd5; sgn = ~sgn;
      end
    end
    chk({name, " ready seen"}, 64'(seen), 64'd1);
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
    chk({name, " result"}, result, exp_res);
    chk({name, " busy in done"}, 64'(busy), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold ready"}, 64'(ready), 64'd1);
      chk({name, " hold result"}, result, exp_res);
    end
  endtask

  task automatic release_start();
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit any_ready;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; dvd = '0; dvs = '0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);

    chk("model 100/7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    chk("model -7/2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model ovf s", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h00000000, 32'h80000000});
    chk("model ovf u", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b0), {32'h80000000, 32'h00000000});

    run_op("udiv 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
    release_start();
    @(posedge clk);
    @(negedge clk);
    chk("drop ready", 64'(ready), 64'd0);
    chk("drop busy", 64'(busy), 64'd0);

    run_op("sdiv -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    release_start();
    run_op("sdiv 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 5);
    release_start();
    // Restart immediately in the first IDLE cycle after DONE.
    run_op("ovf signed", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, 0);
    release_start();
    run_op("ovf unsigned", 32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h00000000}, 33, 0);
    release_start();
    run_op("udiv max/1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h00000000, 32'hFFFFFFFF}, 33, 0);
    release_start();
    run_op("div zero", 32'd1234, 32'd0, 1'b1, 64'd0, 2, 2);
    release_start();

    // Annul in cycle 10 of RUN.
    drive(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #2;
    annul = 1'b0;
    @(negedge clk);
    chk("annul busy", 64'(busy), 64'd0);
    any_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) any_ready = 1'b1;
    end
    chk("annul no ready", 64'(any_ready), 64'd0);
    run_op("after annul 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);
    release_start();

    // annul together with start in IDLE: not accepted.
    @(posedge clk);
    #2;
    start = 1'b1; annul = 1'b1; dvd = 32'd5; dvs = 32'd1;
    @(negedge clk);
    chk("idle annul busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2;
    start = 1'b0; annul = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle annul ready", 64'(ready), 64'd0);

    // Annul while in the divide-by-zero state.
    drive(32'd5, 32'd0, 1'b0);
    @(posedge clk);
    #2;
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #2;
    annul = 1'b0;
    any_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready) any_ready = 1'b1;
    end
    chk("dz annul no ready", 64'(any_ready), 64'd0);

    // Reset in cycle 15 of RUN.
    drive(32'hFFFFFF9C, 32'd7, 1'b1);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst result", result, 64'd0);

    run_op("sdiv -100/-7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'h0000000E}, 33, 1);
    release_start();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
